// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter driving a registered-select 2:1 mux.
// Define MUX_ARB_WATCHDOG_EN to add a stall watchdog that releases a stuck grant.
module mux_rr_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy,
    output logic             timeout_flag,
    output logic [1:0]       dbg_state
);

    // Handshake: a beat moves when out_valid and out_ready are high in the
    // same cycle; only the granted requester ever sees ready, which mirrors out_ready.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mux_rr_arbiter: TIMEOUT must be within 1..255");
    end

    state_t state_q, state_d;
    logic   sel_q, sel_d;
    logic   last_q, last_d;
    logic   in_grant, gnt_valid, other_valid, hs, stall, wd_fire;

    always_comb begin
        in_grant    = (state_q == GRANT0) || (state_q == GRANT1);
        gnt_valid   = (state_q == GRANT1) ? req1_valid : req0_valid;
        other_valid = (state_q == GRANT1) ? req0_valid : req1_valid;
        hs          = in_grant && gnt_valid && out_ready;
        stall       = in_grant && gnt_valid && !out_ready;
    end

    assign out_data   = sel_q ? req1_data : req0_data;
    assign out_valid  = in_grant && gnt_valid;
    assign req0_ready = (state_q == GRANT0) && out_ready;
    assign req1_ready = (state_q == GRANT1) && out_ready;
    assign sel        = sel_q;
    assign busy       = in_grant;
    assign dbg_state  = state_q;

`ifdef MUX_ARB_WATCHDOG_EN
    localparam logic [7:0] STALL_LIM = 8'(TIMEOUT - 1);

    logic [7:0] stall_q, stall_d;
    logic       flag_q;

    // Fires on the stalled cycle that brings the count up to TIMEOUT.
    assign wd_fire      = stall && (stall_q == STALL_LIM);
    assign timeout_flag = flag_q;

    always_comb begin
        stall_d = stall_q;
        if (hs || (state_d != state_q)) begin
            stall_d = 8'd0;
        end else if (stall) begin
            stall_d = stall_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 8'd0;
            flag_q  <= 1'b0;
        end else begin
            stall_q <= stall_d;
            flag_q  <= wd_fire;
        end
    end
`else
    assign wd_fire      = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    state_d = last_q ? GRANT0 : GRANT1;
                end else if (req0_valid) begin
                    state_d = GRANT0;
                end else if (req1_valid) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (wd_fire) begin
                    state_d = IDLE;
                end else if ((hs || !gnt_valid) && other_valid) begin
                    state_d = (state_q == GRANT0) ? GRANT1 : GRANT0;
                end else if (!req0_valid && !req1_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == GRANT0 && state_q != GRANT0) begin
            sel_d  = 1'b0;
            last_d = 1'b0;
        end else if (state_d == GRANT1 && state_q != GRANT1) begin
            sel_d  = 1'b1;
            last_d = 1'b1;
        end
        // A released requester counts as served so the other one wins the next tie.
        if (wd_fire) begin
            last_d = (state_q == GRANT1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus random traffic against a reference model.
module tb_mux_rr_arbiter;

    localparam int W  = 8;
    localparam int TO = 15;
`ifdef MUX_ARB_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         v0, v1, ordy;
    logic [W-1:0] d0, d1;
    logic         r0, r1, out_valid, sel, busy, timeout_flag;
    logic [W-1:0] out_data;
    logic [1:0]   dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    // Reference model: owner -1 = nobody, else requester index.
    int m_owner;
    bit m_sel, m_last, m_flag;
    int m_stall;

    mux_rr_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
        .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
        .out_valid(out_valid), .out_data(out_data), .out_ready(ordy),
        .sel(sel), .busy(busy), .timeout_flag(timeout_flag), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_sel   = 1'b0;
        m_last  = 1'b1;
        m_stall = 0;
        m_flag  = 1'b0;
    endtask

    task automatic model_check();
        logic         e_ov;
        logic [W-1:0] e_data;
        e_ov   = (m_owner == 0) ? v0 : (m_owner == 1) ? v1 : 1'b0;
        e_data = m_sel ? d1 : d0;
        check("busy", busy, (m_owner >= 0));
        check("sel", sel, m_sel);
        check("out_valid", out_valid, e_ov);
        check("out_data", out_data, e_data);
        check("req0_ready", r0, (m_owner == 0) && ordy);
        check("req1_ready", r1, (m_owner == 1) && ordy);
        check("timeout_flag", timeout_flag, m_flag);
        if (e_ov && ordy) exp_q.push_back(e_data);
        if (out_valid === 1'b1 && ordy) begin
            check("sb_has_beat", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("sb_beat", out_data, exp_q.pop_front());
        end
    endtask

    task automatic model_update();
        int k, nxt;
        bit vk, vo, hs, stalled;
        if (rst) begin
            model_reset();
        end else begin
            m_flag = 1'b0;
            nxt    = m_owner;
            if (m_owner < 0) begin
                if (v0 && v1) nxt = m_last ? 0 : 1;
                else if (v0)  nxt = 0;
                else if (v1)  nxt = 1;
            end else begin
                k       = m_owner;
                vk      = (k == 1) ? v1 : v0;
                vo      = (k == 1) ? v0 : v1;
                hs      = vk && ordy;
                stalled = vk && !ordy;
                if (WD_EN && stalled && (m_stall + 1 >= TO)) begin
                    nxt    = -1;
                    m_last = (k == 1);
                    m_flag = 1'b1;
                end else if ((hs || !vk) && vo) begin
                    nxt = 1 - k;
                end else if (!v0 && !v1) begin
                    nxt = -1;
                end
                if (nxt != m_owner || hs) m_stall = 0;
                else if (stalled) m_stall++;
            end
            if (nxt >= 0 && nxt != m_owner) begin
                m_sel   = (nxt == 1);
                m_last  = (nxt == 1);
                m_stall = 0;
            end
            m_owner = nxt;
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit r, input bit a0, input logic [W-1:0] x0,
                        input bit a1, input logic [W-1:0] x1, input bit rd);
        rst = r; v0 = a0; d0 = x0; v1 = a1; d1 = x1; ordy = rd;
        #1;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        int fired_at;
        logic [W-1:0] seen [4];

        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; ordy = 1'b0; d0 = '0; d1 = '0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_sel", sel, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_flag", timeout_flag, 0);
        check("rst_r0", r0, 0);

        // Scenario 1: lone req0 granted the next cycle.
        step(0, 1, 8'hA5, 0, 8'h00, 1);
        check("s1_busy", busy, 1);
        check("s1_sel", sel, 0);
        check("s1_data", out_data, 8'hA5);
        check("s1_r0", r0, 1);
        check("s1_r1", r1, 0);

        // Scenario 2: continuous tie alternates without bubbles.
        step(1, 0, 8'h00, 0, 8'h00, 0);
        step(0, 1, 8'h11, 1, 8'h22, 1);
        for (int i = 0; i < 4; i++) begin
            check("s2_valid", out_valid, 1);
            seen[i] = out_data;
            step(0, 1, 8'h11, 1, 8'h22, 1);
        end
        check("s2_beat0", seen[0], 8'h11);
        check("s2_beat1", seen[1], 8'h22);
        check("s2_beat2", seen[2], 8'h11);
        check("s2_beat3", seen[3], 8'h22);

        // Scenario 3: req1 drops while req0 waits.
        step(1, 0, 8'h00, 0, 8'h00, 0);
        step(0, 0, 8'h00, 1, 8'h3C, 0);
        check("s3_g1_sel", sel, 1);
        step(0, 1, 8'h4B, 0, 8'h3C, 0);
        check("s3_sel", sel, 0);
        check("s3_busy", busy, 1);
        check("s3_r1", r1, 0);

        // Scenario 4: reset mid-grant aborts it and restores req0 priority.
        step(0, 0, 8'h00, 1, 8'h77, 1);
        step(0, 0, 8'h00, 1, 8'h77, 0);
        check("s4_g1", sel, 1);
        step(1, 0, 8'h00, 1, 8'h77, 0);
        check("s4_busy", busy, 0);
        check("s4_sel", sel, 0);
        check("s4_out_valid", out_valid, 0);
        step(0, 1, 8'h66, 1, 8'h77, 1);
        check("s4_tie_sel", sel, 0);

`ifdef MUX_ARB_WATCHDOG_EN
        // Scenario 5: stalled grant released by the watchdog.
        step(1, 0, 8'h00, 0, 8'h00, 0);
        step(0, 1, 8'h5A, 0, 8'h00, 0);
        fired_at = 0;
        for (int i = 1; i <= 40 && fired_at == 0; i++) begin
            if (timeout_flag === 1'b1) fired_at = i;
            else step(0, 1, 8'h5A, 0, 8'h00, 0);
        end
        check("s5_fire_cycle", fired_at, 16);
        check("s5_idle", busy, 0);
        step(0, 1, 8'h5A, 0, 8'h00, 0);
        check("s5_flag_cleared", timeout_flag, 0);
        check("s5_regrant", busy, 1);
        step(0, 0, 8'h00, 0, 8'h00, 0);
        step(0, 1, 8'h5A, 1, 8'hC3, 1);
        check("s5_tie_sel", sel, 1);
`else
        // Scenario 6: without a watchdog the stalled grant is held.
        step(1, 0, 8'h00, 0, 8'h00, 0);
        step(0, 1, 8'h5A, 0, 8'h00, 0);
        for (int i = 0; i < 100; i++) begin
            check("s6_busy", busy, 1);
            check("s6_sel", sel, 0);
            check("s6_flag", timeout_flag, 0);
            step(0, 1, 8'h5A, 0, 8'h00, 0);
        end
`endif

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 3) != 0), W'($urandom),
                 ($urandom_range(0, 3) != 0), W'($urandom),
                 ($urandom_range(0, 4) != 0));
        end
        step(0, 0, 8'h00, 0, 8'h00, 1);
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data width of each requester and of the output.
REQ-002 Parameter TIMEOUT, default 15: stall cycles tolerated before the watchdog fires (range 1..255).
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has data.
REQ-006 req0_data  input  WIDTH  requester 0 data.
REQ-007 req0_ready  output  1  requester 0 beat accepted.
REQ-008 req1_valid  input  1  requester 1 has data.
REQ-009 req1_data  input  WIDTH  requester 1 data.
REQ-010 req1_ready  output  1  requester 1 beat accepted.
REQ-011 out_valid  output  1  muxed beat valid.
REQ-012 out_data  output  WIDTH  2:1 mux output, selected by sel.
REQ-013 out_ready  input  1  sink accepts beat.
REQ-014 sel  output  1  registered mux select (0 = req0, 1 = req1).
REQ-015 busy  output  1  high when state is GRANT0 or GRANT1.
REQ-016 timeout_flag  output  1  one-cycle pulse when the watchdog releases a grant.

Function
REQ-017 FSM states SHALL be IDLE, GRANT0 and GRANT1; the state and a last-served bit "last" SHALL be registered.
REQ-018 out_data SHALL equal req0_data when sel=0 and req1_data when sel=1, combinationally, in every state.
REQ-019 In IDLE: out_valid=0, req0_ready=0, req1_ready=0, and sel holds its previous value.
REQ-020 In GRANTk: sel=k, out_valid=reqk_valid, reqk_ready=out_ready, and the other requester's ready=0.
REQ-021 IDLE -> GRANTk SHALL occur one cycle after reqk_valid is sampled high; if both are valid, k = 1-last (round robin).
REQ-022 In GRANTk: if (handshake or !reqk_valid) and the other requester is valid, the FSM SHALL go to GRANT(1-k) with no idle bubble.
REQ-023 In GRANTk: if neither requester is valid, the FSM SHALL return to IDLE; otherwise it SHALL stay in GRANTk.
REQ-024 "last" SHALL be updated to k on every entry into GRANTk.
REQ-025 A handshake is defined as out_valid and out_ready both high in the same cycle; a beat is never duplicated or dropped, except on a watchdog release.
REQ-026 reqk_ready SHALL never be high while the FSM is not in GRANTk.

Reset
REQ-027 While rst=1 at a clock edge: state=IDLE, sel=0, last=1 (req0 wins the first tie), stall counter=0, timeout_flag=0.
REQ-028 An rst asserted mid-grant SHALL abort the grant; outputs follow REQ-019 from the next cycle, and the pending beat is not transferred.

Configuration
REQ-029 Macro MUX_ARB_WATCHDOG_EN SHALL compile in a stall counter and watchdog.
REQ-030 With the macro: the counter increments each GRANTk cycle with out_valid=1 and out_ready=0, and clears on handshake or state change.
REQ-031 With the macro: when the counter reaches TIMEOUT, the FSM SHALL go to IDLE, set last=k, and pulse timeout_flag for one cycle.
REQ-032 Without the macro: there is no counter, timeout_flag is tied to 0, and a grant is held indefinitely under stall.

Verification
REQ-033 Scenario 1: reset, then req0_valid=1, req0_data=8'hA5, out_ready=1 -> GRANT0 next cycle, sel=0, out_data=8'hA5, req0_ready=1.
REQ-034 Scenario 2: both valid (8'h11 / 8'h22) continuously, out_ready=1 -> out_data alternates 11,22,11,22 starting with 11, with no idle cycle.
REQ-035 Scenario 3: GRANT1 active and req1_valid drops while req0_valid=1 -> next cycle GRANT0, sel=0, req1_ready=0.
REQ-036 Scenario 4: rst=1 pulsed during GRANT1 -> next cycle busy=0, sel=0, out_valid=0; the next tie grants req0.
REQ-037 Scenario 5 (MUX_ARB_WATCHDOG_EN, TIMEOUT=15): req0_valid=1, out_ready=0 -> timeout_flag pulses after 15 stalled cycles, then IDLE, then req1 gets priority on the next tie.
REQ-038 Scenario 6 (no macro): same stimulus as Scenario 5 held for 100 cycles -> stays in GRANT0, timeout_flag=0 throughout.
